// File: rtl/dg_cmd_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dg_cmd_sched
// Description : Round-robin scheduler that merges N_REQ show-ahead command
//               FIFOs into one show-ahead command port for dg_fetch. One
//               command per grant is held in a one-entry output buffer.
//               Optional macro DG_SCHED_PRIO_EN: arbitrate on the 3-bit prior
//               field [6:4], with round-robin tie-break.
// Revision    : 1.0 - initial release
// ============================================================================
module dg_cmd_sched #(
    parameter  int N_REQ  = 4,
    parameter  int FIFO_W = 32,
    localparam int PTR_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        i_req_ready,
    input  logic [N_REQ*FIFO_W-1:0] i_req_data,
    output logic [N_REQ-1:0]        o_req_rden,
    output logic                    o_fifo_ready,
    output logic [FIFO_W-1:0]       o_fifo_data,
    input  logic                    i_fifo_rden,
    output logic [PTR_W-1:0]        o_last_grant,
    output logic                    o_rd_err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_POP  = 1'b1;

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  win;
    logic              found;
    logic              load;
    logic [N_REQ-1:0]  win_onehot;
    logic [FIFO_W-1:0] win_data;
    int                idx;
`ifdef DG_SCHED_PRIO_EN
    logic [2:0]        pri;
    logic [2:0]        best_pri;
`endif

    // Winner search: walk sources starting at rr+1, rr itself visited last
    always_comb begin
        win   = rr_ptr;
        found = 1'b0;
        idx   = 0;
`ifdef DG_SCHED_PRIO_EN
        pri      = 3'd0;
        best_pri = 3'd0;
`endif
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % N_REQ;
            if (i_req_ready[idx]) begin
`ifdef DG_SCHED_PRIO_EN
                // Strictly greater keeps the earliest source in rr order on ties
                pri = i_req_data[idx*FIFO_W+4 +: 3];
                if (!found || (pri > best_pri)) begin
                    found    = 1'b1;
                    best_pri = pri;
                    win      = PTR_W'(idx);
                end
`else
                if (!found) begin
                    found = 1'b1;
                    win   = PTR_W'(idx);
                end
`endif
            end
        end
    end

    // Head word and pop strobe of the selected source
    always_comb begin
        win_onehot      = '0;
        win_onehot[win] = 1'b1;
        win_data        = i_req_data[int'(win)*FIFO_W +: FIFO_W];
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: a load always spends one cycle in S_POP for the source pop
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (load) state_nxt = S_POP;
            S_POP:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM output: load only from S_IDLE when the buffer is free or being drained
    always_comb begin
        load = 1'b0;
        if (state == S_IDLE) begin
            load = found && (!o_fifo_ready || i_fifo_rden);
        end
    end

    // Output buffer, source pop pulse, round-robin pointer and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_req_rden   <= '0;
            o_fifo_ready <= 1'b0;
            o_fifo_data  <= '0;
            rr_ptr       <= PTR_W'(N_REQ - 1);
            o_rd_err     <= 1'b0;
        end else begin
            if (load) begin
                // A concurrent consumer pop is absorbed: ready stays high
                o_fifo_data  <= win_data;
                o_fifo_ready <= 1'b1;
                o_req_rden   <= win_onehot;
                rr_ptr       <= win;
            end else begin
                o_req_rden <= '0;
                if (i_fifo_rden && o_fifo_ready) begin
                    o_fifo_ready <= 1'b0;
                end
            end
            if (i_fifo_rden && !o_fifo_ready) begin
                o_rd_err <= 1'b1;
            end
        end
    end

    assign o_last_grant = rr_ptr;

endmodule
`default_nettype wire

// File: tb/tb_dg_cmd_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dg_cmd_sched
// Description : Directed bench for dg_cmd_sched. Stimulus queues expected
//               grants; a monitor checks every source pop pulse against them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dg_cmd_sched;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_rden;
    logic           fifo_ready;
    logic [W-1:0]   fifo_data;
    logic           fifo_rden;
    logic [1:0]     last_grant;
    logic           rd_err;

    dg_cmd_sched #(.N_REQ(N), .FIFO_W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_ready  (req_ready),
        .i_req_data   (req_data),
        .o_req_rden   (req_rden),
        .o_fifo_ready (fifo_ready),
        .o_fifo_data  (fifo_data),
        .i_fifo_rden  (fifo_rden),
        .o_last_grant (last_grant),
        .o_rd_err     (rd_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  src;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] src_mem [N][8];
    int          src_rd [N];
    int          src_wr [N];
    bit          auto_pop;
    logic [N-1:0] prev_rden = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic refresh();
        for (int k = 0; k < N; k++) begin
            req_ready[k]        = (src_rd[k] != src_wr[k]);
            req_data[k*W +: W]  = req_ready[k] ? src_mem[k][src_rd[k] % 8] : 32'h0;
        end
    endtask

    task automatic push_src(input int k, input logic [31:0] w);
        src_mem[k][src_wr[k] % 8] = w;
        src_wr[k]++;
        refresh();
    endtask

    task automatic expect_grant(input int k, input logic [31:0] w);
        exp_t e;
        e.src  = 2'(k);
        e.data = w;
        exp_q.push_back(e);
    endtask

    // One cycle: at the falling edge, sources popped by a pulse advance
    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            if (req_rden[k] && (src_rd[k] != src_wr[k])) src_rd[k]++;
        end
        refresh();
        if (auto_pop) fifo_rden = fifo_ready;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        auto_pop  = 1'b0;
        fifo_rden = 1'b0;
        for (int k = 0; k < N; k++) begin
            src_rd[k] = 0;
            src_wr[k] = 0;
        end
        refresh();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        tick();
        tick();
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Monitor: every source pop pulse must match the next expected grant
    always @(negedge clk) begin
        logic [3:0] oh;
        exp_t       e;
        if (req_rden != '0) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL grant_unexpected: rden=%b data=%0h, no grant expected", req_rden, fifo_data);
            end else begin
                e  = exp_q.pop_front();
                oh = 4'b0001 << e.src;
                if (req_rden !== oh || fifo_data !== e.data || last_grant !== e.src ||
                    fifo_ready !== 1'b1 || prev_rden != '0) begin
                    miscompares++;
                    $display("FAIL grant: rden=%b data=%0h last=%0d ready=%b prev_rden=%b, expected rden=%b data=%0h last=%0d ready=1 prev_rden=0",
                             req_rden, fifo_data, last_grant, fifo_ready, prev_rden, oh, e.data, e.src);
                end
            end
        end
        prev_rden = req_rden;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] w0;
        logic [31:0] w1;
        // ---- reset values, then a single-source grant
        rst_n     = 1'b0;
        auto_pop  = 1'b0;
        fifo_rden = 1'b0;
        for (int k = 0; k < N; k++) begin
            src_rd[k] = 0;
            src_wr[k] = 0;
        end
        refresh();
        tick();
        check("rst_rden",  32'(req_rden),   32'h0);
        check("rst_ready", 32'(fifo_ready), 32'h0);
        check("rst_data",  fifo_data,       32'h0);
        check("rst_last",  32'(last_grant), 32'd3);
        check("rst_err",   32'(rd_err),     32'h0);
        tick();
        rst_n = 1'b1;
        push_src(0, 32'h0000_0155);
        expect_grant(0, 32'h0000_0155);
        tick();
        check("t1_ready", 32'(fifo_ready), 32'h1);
        check("t1_data",  fifo_data,       32'h0000_0155);
        check("t1_last",  32'(last_grant), 32'd0);
        tick();
        check("t1_rden_pulse", 32'(req_rden), 32'h0);
        fifo_rden = 1'b1;
        tick();
        fifo_rden = 1'b0;
        check("t1_popped", 32'(fifo_ready), 32'h0);
        check("t1_err",    32'(rd_err),     32'h0);
        drain("t1_drain");

        // ---- all four sources ready, consumer pops every full cycle
        do_reset();
        for (int j = 0; j < 2; j++)
            for (int k = 0; k < N; k++)
                push_src(k, 32'hC000_0000 | (k << 12) | (j << 8) | k);
        for (int j = 0; j < 2; j++)
            for (int k = 0; k < N; k++)
                expect_grant(k, 32'hC000_0000 | (k << 12) | (j << 8) | k);
        auto_pop = 1'b1;
        drain("rr_drain");
        auto_pop  = 1'b0;
        fifo_rden = 1'b0;

`ifdef DG_SCHED_PRIO_EN
        // ---- priority arbitration with round-robin tie-break from rr=0
        do_reset();
        push_src(0, 32'h0000_0010);
        expect_grant(0, 32'h0000_0010);
        auto_pop = 1'b1;
        drain("prio_setup");
        push_src(0, 32'h0000_0110);
        push_src(1, 32'h0000_0151);
        push_src(1, 32'h0000_0251);
        push_src(2, 32'h0000_0152);
        push_src(2, 32'h0000_0252);
        push_src(3, 32'h0000_0133);
        expect_grant(1, 32'h0000_0151);
        expect_grant(2, 32'h0000_0152);
        expect_grant(1, 32'h0000_0251);
        expect_grant(2, 32'h0000_0252);
        expect_grant(3, 32'h0000_0133);
        expect_grant(0, 32'h0000_0110);
        drain("prio_drain");
        auto_pop  = 1'b0;
        fifo_rden = 1'b0;
`endif

        // ---- buffer full: no grant until a pop, then load at the pop edge
        do_reset();
        w0 = 32'h5A00_0122;
        w1 = 32'hA500_0342;
        push_src(2, w0);
        push_src(2, w1);
        expect_grant(2, w0);
        tick();
        for (int c = 0; c < 10; c++) begin
            tick();
            check("full_no_rden", 32'(req_rden),   32'h0);
            check("full_ready",   32'(fifo_ready), 32'h1);
        end
        check("full_data", fifo_data, w0);
        fifo_rden = 1'b1;
        expect_grant(2, w1);
        tick();
        fifo_rden = 1'b0;
        check("reload_ready", 32'(fifo_ready), 32'h1);
        check("reload_data",  fifo_data,       w1);
        tick();
        fifo_rden = 1'b1;
        tick();
        fifo_rden = 1'b0;
        check("final_pop_ready", 32'(fifo_ready), 32'h0);
        check("no_err_yet",      32'(rd_err),     32'h0);

        // ---- pop while empty: sticky error, buffer untouched
        fifo_rden = 1'b1;
        tick();
        fifo_rden = 1'b0;
        check("err_set",   32'(rd_err),     32'h1);
        check("err_ready", 32'(fifo_ready), 32'h0);
        check("err_data",  fifo_data,       w1);
        tick();
        tick();
        tick();
        check("err_sticky", 32'(rd_err), 32'h1);
        drain("full_drain");

        // ---- reset during the source pop cycle
        do_reset();
        check("rst2_err", 32'(rd_err), 32'h0);
        push_src(3, 32'h3333_0123);
        @(posedge clk);
        #1;
        check("pop_pulse_src3", 32'(req_rden), 32'h8);
        rst_n = 1'b0;
        #1;
        check("async_rden",  32'(req_rden),   32'h0);
        check("async_ready", 32'(fifo_ready), 32'h0);
        check("async_data",  fifo_data,       32'h0);
        check("async_last",  32'(last_grant), 32'd3);
        push_src(0, 32'h0F0F_0200);
        tick();
        tick();
        rst_n = 1'b1;
        expect_grant(0, 32'h0F0F_0200);
        expect_grant(3, 32'h3333_0123);
        auto_pop = 1'b1;
        drain("rst_pop_drain");
        auto_pop  = 1'b0;
        fifo_rden = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
